cpu_mult_pipe: RTL
==================

// Module: cpu_mult_pipe
// PURPOSE
//  Parametrised pipelined integer multiply unit for the soft-CPU execute/memory path.
//  Splits DATA_W x DATA_W into SLICE_W x SLICE_W registered partial products, then sums them.
//  Supports Nios-style MUL (low word) and, optionally, MULXUU/MULXSU/MULXSS (high word).
//  Fully pipelined with valid tracking, stall and flush. Accepts one op per cycle at fixed latency.
// PARAMETERS
//  DATA_W   32  operand/result width; must be a multiple of SLICE_W
//  SLICE_W  16  partial-product slice width; sized to map onto one hard multiplier
//  OUT_REG  1   1 = registered result stage; 0 = sum drives out_result combinationally from stage 2
// PORTS
//  clk            in   1        single clock; all state on rising edge
//  reset          in   1        reset, asynchronous, active-high
//  in_valid       in   1        operation presented this cycle
//  in_op          in   2        00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//  in_src1        in   DATA_W   multiplicand (signed for MULXSU/MULXSS)
//  in_src2        in   DATA_W   multiplier (signed for MULXSS only)
//  stall          in   1        freeze every pipeline register, including valids
//  flush          in   1        drop all in-flight ops
//  out_valid      out  1        out_result holds a completed op
//  out_result     out  DATA_W   low word (MUL) or high word (MULX*) of the 2*DATA_W product
//  out_unsupp     out  1        qualified by out_valid; op was a MULX* in a build without the macro
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - Reset: all valid bits, out_valid, out_result and out_unsupp clear to 0 immediately.
//    Ops in flight when reset asserts are lost.
//  - Latency: LAT = 2 + OUT_REG cycles from an accepted in_valid to out_valid when no stall occurs.
//    Throughput is 1 op/cycle.
//  - Stage 1: register src1, src2, op and valid.
//    Extend each operand to DATA_W+1 bits: sign-extend if that operand is signed for the op, else zero-extend.
//  - Stage 2: register every required slice product, and a sign-correction term for the extended MSBs.
//  - Stage 3: add the shifted partials modulo 2^(2*DATA_W).
//    MUL returns bits [DATA_W-1:0]; MULX* return bits [2*DATA_W-1:DATA_W].
//  - MUL is identical for signed and unsigned operands; no correction term is applied for MUL.
//  - Stall is high: no register changes; in_valid is ignored, so the source must hold the op.
//    out_valid and out_result hold their values.
//  - Flush is high: every stage valid and out_valid clear next edge; in_valid that cycle is discarded.
//    Flush overrides stall. Data registers may keep stale values.
//  - Data registers load only when their stage valid is set, to save power.
//    out_result updates only with out_valid.
//  - Back-to-back ops never interact; results emerge strictly in issue order.
// CONFIGURATION
//  - Macro CPU_MULT_HI_EN.
//  - Defined: all N*N slice products and the sign-correction logic are built; all four ops are legal;
//    out_unsupp = 0.
//  - Undefined: only slice products with i+j < N = DATA_W/SLICE_W are built, and the upper half of
//    each diagonal product is truncated.
//    MULX* ops return the low word with out_unsupp = 1, which the CPU turns into an illegal-instruction trap.
// STRUCTURE
//  - Package cpu_mult_pkg holds the op encodings (OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS),
//    the function op_is_high(op), and the helper localparam N_SLICES.
//  - Sub-module cpu_mult_slice_pp: one registered SLICE_W x SLICE_W unsigned multiply with enable
//    and async clear; instantiated with a generate loop.
//  - Top level holds operand extension, valid pipeline, stall/flush control and the final adder tree.
// TESTING
//  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 after exactly 3 cycles (OUT_REG=1); out_valid pulses 1 cycle.
//  - 0xFFFFFFFF*0xFFFFFFFF high ops -> MULXUU 0xFFFFFFFE, MULXSU 0xFFFFFFFF, MULXSS 0x00000000.
//  - 0x00010000*0x00010000 -> MUL 0x00000000, MULXUU 0x00000001.
//    Four ops issued on consecutive cycles return in order on 4 consecutive cycles.
//  - Stall held 5 cycles mid-stream with 2 ops in flight: no output change, no lost or duplicated
//    result, and both results correct after release.
//  - Flush asserted with 2 ops in flight plus a new in_valid: out_valid stays 0 for LAT cycles.
//    A following op completes normally.
//  - Reset asserted asynchronously between edges with ops in flight: out_valid drops at once and
//    no stale result appears after release.
//    Without the macro, MULXSS -> out_unsupp = 1.

Source files
------------

// File: rtl/cpu_mult_pkg.sv
// Shared definitions for the pipelined integer multiply unit: op encodings,
// operand-signedness helpers and the default slice count.
package cpu_mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } mult_op_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SLICE_W = 16;
  localparam int N_SLICES    = DEF_DATA_W / DEF_SLICE_W;

  // High-word ops return bits [2*DATA_W-1:DATA_W] of the product.
  function automatic logic op_is_high(input mult_op_e op);
    return (op != OP_MUL);
  endfunction

  function automatic logic src1_signed(input mult_op_e op);
    return (op == OP_MULXSU) || (op == OP_MULXSS);
  endfunction

  function automatic logic src2_signed(input mult_op_e op);
    return (op == OP_MULXSS);
  endfunction

endpackage

// File: rtl/cpu_mult_pipe_slice_pp.sv
// One registered SLICE_W x SLICE_W unsigned partial product with load enable
// and asynchronous clear. PROD_W < 2*SLICE_W keeps only the low product bits,
// used where the upper half can never reach the result.
module cpu_mult_slice_pp #(
  parameter int SLICE_W = 16,
  parameter int PROD_W  = 2 * SLICE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic [PROD_W-1:0]  p
);

  // Capture the slice product when the feeding stage holds a valid op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (en) begin
      p <= PROD_W'(a * b);
    end
  end

endmodule

// File: rtl/cpu_mult_pipe.sv
// Pipelined DATA_W x DATA_W integer multiplier: operand register, sliced
// partial-product register, adder tree with optional output register.
// Build option: define CPU_MULT_HI_EN to build the full product and support
// MULXUU/MULXSU/MULXSS; without it those ops return the low word and flag
// out_unsupp.
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic              out_unsupp
);

  localparam int N = DATA_W / SLICE_W;
`ifdef CPU_MULT_HI_EN
  localparam int ACC_W = 2 * DATA_W;
`else
  localparam int ACC_W = DATA_W;
`endif

  logic              s1_valid;
  mult_op_e          s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s2_valid;
  mult_op_e          s2_op;
  logic              load1;
  logic              load2;

  logic [ACC_W-1:0]  term [N*N];
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] sum_result;
  logic              sum_unsupp;

  assign load1 = in_valid && !stall && !flush;
  assign load2 = s1_valid && !stall;

  // Valid pipeline: flush wins over stall, stall freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

  // Stage 1 operand/op capture, only for accepted ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_op <= OP_MUL;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (load1) begin
      s1_op <= mult_op_e'(in_op);
      s1_a  <= in_src1;
      s1_b  <= in_src2;
    end
  end

  // Stage 2 op tag travels alongside the partial products.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_op <= OP_MUL;
    end else if (load2) begin
      s2_op <= s1_op;
    end
  end

`ifdef CPU_MULT_HI_EN
  // Extended operand = -sgn*2^DATA_W + unsigned value, so the signed product
  // is the unsigned product minus (sa*B + sb*A) << DATA_W, modulo 2^(2*DATA_W).
  logic              s1_a_sgn;
  logic              s1_b_sgn;
  logic [DATA_W-1:0] s2_corr;

  // Stage 1 extension bits: set only when the operand is signed for the op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_a_sgn <= 1'b0;
      s1_b_sgn <= 1'b0;
    end else if (load1) begin
      s1_a_sgn <= src1_signed(mult_op_e'(in_op)) && in_src1[DATA_W-1];
      s1_b_sgn <= src2_signed(mult_op_e'(in_op)) && in_src2[DATA_W-1];
    end
  end

  // Stage 2 sign-correction term; only its low DATA_W bits survive the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_corr <= '0;
    end else if (load2) begin
      s2_corr <= (s1_a_sgn ? s1_b : '0) + (s1_b_sgn ? s1_a : '0);
    end
  end
`endif

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
`ifdef CPU_MULT_HI_EN
      localparam int PW    = 2 * SLICE_W;
      localparam bit BUILT = 1'b1;
`else
      localparam int PW    = (i + j == N - 1) ? SLICE_W : 2 * SLICE_W;
      localparam bit BUILT = (i + j < N);
`endif
      if (BUILT) begin : g_on
        logic [PW-1:0] pp;
        cpu_mult_slice_pp #(
          .SLICE_W (SLICE_W),
          .PROD_W  (PW)
        ) u_pp (
          .clk   (clk),
          .reset (reset),
          .en    (load2),
          .a     (s1_a[i*SLICE_W +: SLICE_W]),
          .b     (s1_b[j*SLICE_W +: SLICE_W]),
          .p     (pp)
        );
        assign term[i*N+j] = ACC_W'(pp) << ((i + j) * SLICE_W);
      end else begin : g_off
        assign term[i*N+j] = '0;
      end
    end
  end

  // Stage 3 adder tree and word select.
  always_comb begin
    acc = '0;
    for (int k = 0; k < N * N; k++) begin
      acc = acc + term[k];
    end
`ifdef CPU_MULT_HI_EN
    acc        = acc - {s2_corr, {DATA_W{1'b0}}};
    sum_result = op_is_high(s2_op) ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0];
    sum_unsupp = 1'b0;
`else
    sum_result = acc;
    sum_unsupp = op_is_high(s2_op);
`endif
  end

  if (OUT_REG != 0) begin : g_out_reg
    // Output register: result and flag load only alongside a valid op.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_valid  <= 1'b0;
        out_result <= '0;
        out_unsupp <= 1'b0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (!stall) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_result <= sum_result;
          out_unsupp <= sum_unsupp;
        end
      end
    end
  end else begin : g_out_comb
    assign out_valid  = s2_valid;
    assign out_result = sum_result;
    assign out_unsupp = sum_unsupp;
  end

endmodule
